xtea_enc: RTL and testbench
===========================

# xtea_enc

XTEA encryption engine: the transmit-side partner of the team's XTEA decrypter, using the same key and block packing. It encrypts two independent 64-bit XTEA blocks in parallel over 32 rounds with a 128-bit key. It sits in front of the link/storage path so that its output, fed to the decrypter with the same key, returns the original plaintext. Control is an iterative FSM: one start pulse, a multi-cycle run, then a one-cycle ready pulse with the result held on `data_o`.

## Interface
- No parameters; round count (32) and delta (32'h9E3779B9) are fixed.
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low; asserted (0) forces the idle state
- start  input  1  request; sampled only in IDLE
- v  input  128  plaintext: y0=v[31:0], z0=v[63:32], y1=v[95:64], z1=v[127:96]
- k  input  128  key: k0=k[31:0], k1=k[63:32], k2=k[95:64], k3=k[127:96]
- busy  output  1  high while a block pair is being processed (states other than IDLE)
- ready  output  1  one-cycle pulse; `data_o` is valid from this pulse onward
- data_o  output  128  ciphertext, same packing as `v`; held until the next completion

## Operation
- States: IDLE, ROUND_Y, ROUND_SUM, ROUND_Z, DONE.
- IDLE with start=1:
  - Capture v and k into internal registers; later changes on the inputs have no effect.
  - Set sum=0 and round counter i=0, then go to ROUND_Y.
- ROUND_Y: for each pair, y += (((z<<4)^(z>>5)) + z) ^ (sum + k[sum[1:0]]).
- ROUND_SUM: sum += delta.
- ROUND_Z: for each pair, z += (((y<<4)^(y>>5)) + y) ^ (sum + k[sum[12:11]]).
  - If i==31, go to DONE; otherwise i += 1 and return to ROUND_Y.
- DONE: write data_o from {z1,y1,z0,y0}, pulse ready=1, go to IDLE.
- Arithmetic: all values are 32-bit unsigned, wrapping modulo 2^32; shifts are logical.
- `start` outside IDLE is ignored and no request is queued.
- `start` held high: a new run starts on every return to IDLE, including the cycle in which ready is high.

## Timing
- Reset values: ready=0, busy=0, data_o=0, FSM in IDLE. sum and i are don't-care until loaded.
- Reset asserted mid-run aborts the run. No ready pulse is produced, data_o returns to 0, and there is no partial output.
- Latency: start sampled at clock edge E0. Round r (0..31) occupies edges E0+3r+1 .. E0+3r+3. DONE executes at E0+97, so ready and the new data_o are visible after E0+97 for exactly one cycle.
- busy is high after E0 and low again after E0+97, i.e. coincident with the ready cycle.
- Throughput: at most one block pair per 98 cycles, with start held or re-pulsed in the ready cycle.

## Configuration
- `XTEA_ENC_FAST_EN` defined:
  - ROUND_Y, ROUND_SUM and ROUND_Z collapse into one ROUND state computing a full round per cycle.
  - Order within that cycle: y uses the old sum, z uses sum+delta and the new y.
  - DONE is at E0+33, ready follows after E0+33, busy is high for 33 cycles.
- Not defined: the 3-cycle-per-round datapath above.
- Ciphertext is identical in both modes.

## Test plan
- Zero vector: v=0, k=0, start pulse -> ready after 97 cycles (33 with FAST); y0=32'hDEE9D4D8, z0=32'hF7131ED9, and pair 1 is identical.
- Standard vector: y0=32'h41424344, z0=32'h45464748, k0..k3=32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F -> y0=32'h497DF3D0, z0=32'h72612CB5.
- Input isolation: change v, k and pulse start during the run -> result equals the captured operands; no second run starts; busy never drops early.
- Reset mid-run: pull reset low at cycle 40 -> ready=0, busy=0, data_o=0 immediately; after release, a fresh start gives the correct result.
- Back-to-back: hold start=1 across two completions with different v -> two ready pulses 98 cycles apart, each with correct ciphertext; data_o holds between pulses.
- Round-trip: random v/k through xtea_enc and then the decrypter with the same k -> recovered v equals the original for 100 random vectors.

Source files
------------

// File: rtl/xtea_enc.sv
// XTEA encryption engine: two independent 64-bit blocks, 32 rounds, 128-bit key.
// Iterative datapath, three states per round by default.
// Optional build macro: XTEA_ENC_FAST_EN -- one full round per cycle.
`timescale 1ns/1ps

module xtea_enc (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] v,
  input  logic [127:0] k,
  output logic         busy,
  output logic         ready,
  output logic [127:0] data_o
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned CNT_W   = 5;
  localparam logic [WORD_W-1:0] DELTA      = 32'h9E3779B9;
  localparam logic [CNT_W-1:0]  LAST_ROUND = 5'd31;

`ifdef XTEA_ENC_FAST_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ROUND_Y   = 3'd1,
    ROUND_SUM = 3'd2,
    ROUND_Z   = 3'd3,
    DONE      = 3'd4
  } state_t;
`endif

  state_t state_q, state_d;

  logic [WORD_W-1:0]      y0_q, z0_q, y1_q, z1_q, sum_q;
  logic [WORD_W-1:0]      y0_d, z0_d, y1_d, z1_d, sum_d;
  logic [CNT_W-1:0]       i_q, i_d;
  logic [3:0][WORD_W-1:0] key_q, key_d;
  logic                   busy_d, ready_d;
  logic [BLOCK_W-1:0]     data_d;

  // XTEA Feistel mixing term applied to one half-word
  function automatic logic [WORD_W-1:0] mix(input logic [WORD_W-1:0] x);
    return ((x << 4) ^ (x >> 5)) + x;
  endfunction

  // Shared round arithmetic; the z half sees either the registered or the freshly computed y/sum
  logic [WORD_W-1:0] sum_inc, y0_rnd, y1_rnd, z_sum, z_y0, z_y1, z0_rnd, z1_rnd;

  assign sum_inc = sum_q + DELTA;
  assign y0_rnd  = y0_q + (mix(z0_q) ^ (sum_q + key_q[sum_q[1:0]]));
  assign y1_rnd  = y1_q + (mix(z1_q) ^ (sum_q + key_q[sum_q[1:0]]));
`ifdef XTEA_ENC_FAST_EN
  assign z_sum   = sum_inc;
  assign z_y0    = y0_rnd;
  assign z_y1    = y1_rnd;
`else
  assign z_sum   = sum_q;
  assign z_y0    = y0_q;
  assign z_y1    = y1_q;
`endif
  assign z0_rnd  = z0_q + (mix(z_y0) ^ (z_sum + key_q[z_sum[12:11]]));
  assign z1_rnd  = z1_q + (mix(z_y1) ^ (z_sum + key_q[z_sum[12:11]]));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef XTEA_ENC_FAST_EN
      IDLE:  if (start) state_d = ROUND;
      ROUND: if (i_q == LAST_ROUND) state_d = DONE;
`else
      IDLE:      if (start) state_d = ROUND_Y;
      ROUND_Y:   state_d = ROUND_SUM;
      ROUND_SUM: state_d = ROUND_Z;
      ROUND_Z:   state_d = (i_q == LAST_ROUND) ? DONE : ROUND_Y;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    y0_d    = y0_q;
    z0_d    = z0_q;
    y1_d    = y1_q;
    z1_d    = z1_q;
    sum_d   = sum_q;
    i_d     = i_q;
    key_d   = key_q;
    data_d  = data_o;
    ready_d = 1'b0;
    busy_d  = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d = k;
          y0_d  = v[31:0];
          z0_d  = v[63:32];
          y1_d  = v[95:64];
          z1_d  = v[127:96];
          sum_d = '0;
          i_d   = '0;
        end
      end
`ifdef XTEA_ENC_FAST_EN
      ROUND: begin
        y0_d  = y0_rnd;
        y1_d  = y1_rnd;
        sum_d = sum_inc;
        z0_d  = z0_rnd;
        z1_d  = z1_rnd;
        if (i_q != LAST_ROUND) i_d = i_q + 5'd1;
      end
`else
      ROUND_Y: begin
        y0_d = y0_rnd;
        y1_d = y1_rnd;
      end
      ROUND_SUM: sum_d = sum_inc;
      ROUND_Z: begin
        z0_d = z0_rnd;
        z1_d = z1_rnd;
        if (i_q != LAST_ROUND) i_d = i_q + 5'd1;
      end
`endif
      DONE: begin
        data_d  = {z1_q, y1_q, z0_q, y0_q};
        ready_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      y0_q   <= '0;
      z0_q   <= '0;
      y1_q   <= '0;
      z1_q   <= '0;
      sum_q  <= '0;
      i_q    <= '0;
      key_q  <= '0;
      data_o <= '0;
      ready  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      y0_q   <= y0_d;
      z0_q   <= z0_d;
      y1_q   <= y1_d;
      z1_q   <= z1_d;
      sum_q  <= sum_d;
      i_q    <= i_d;
      key_q  <= key_d;
      data_o <= data_d;
      ready  <= ready_d;
      busy   <= busy_d;
    end
  end

endmodule

// File: tb/tb_xtea_enc.sv
// Self-checking bench for xtea_enc: scoreboard of reference ciphertexts, round-trip decrypt.
`timescale 1ns/1ps

module tb_xtea_enc;

`ifdef XTEA_ENC_FAST_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 97;
`endif
  localparam logic [31:0] DELTA = 32'h9E3779B9;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [127:0] v = '0;
  logic [127:0] k = '0;
  logic         busy, ready;
  logic [127:0] data_o;

  xtea_enc dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .v      (v),
    .k      (k),
    .busy   (busy),
    .ready  (ready),
    .data_o (data_o)
  );

  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
    logic [127:0] key;
    int           e0;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference XTEA on one 64-bit block, returned as {z,y}
  function automatic logic [63:0] enc_blk(input logic [31:0] yi, input logic [31:0] zi,
                                          input logic [127:0] key);
    logic [31:0] y, z, s;
    logic [31:0] kw[4];
    for (int i = 0; i < 4; i++) kw[i] = key[32*i +: 32];
    y = yi; z = zi; s = 32'd0;
    for (int r = 0; r < 32; r++) begin
      y = y + ((((z << 4) ^ (z >> 5)) + z) ^ (s + kw[s[1:0]]));
      s = s + DELTA;
      z = z + ((((y << 4) ^ (y >> 5)) + y) ^ (s + kw[s[12:11]]));
    end
    return {z, y};
  endfunction

  // Reference XTEA decryption of one block, returned as {z,y}
  function automatic logic [63:0] dec_blk(input logic [31:0] yi, input logic [31:0] zi,
                                          input logic [127:0] key);
    logic [31:0] y, z, s;
    logic [31:0] kw[4];
    for (int i = 0; i < 4; i++) kw[i] = key[32*i +: 32];
    y = yi; z = zi; s = DELTA * 32;
    for (int r = 0; r < 32; r++) begin
      z = z - ((((y << 4) ^ (y >> 5)) + y) ^ (s + kw[s[12:11]]));
      s = s - DELTA;
      y = y - ((((z << 4) ^ (z >> 5)) + z) ^ (s + kw[s[1:0]]));
    end
    return {z, y};
  endfunction

  function automatic logic [127:0] enc128(input logic [127:0] p, input logic [127:0] key);
    return {enc_blk(p[95:64], p[127:96], key), enc_blk(p[31:0], p[63:32], key)};
  endfunction

  function automatic logic [127:0] dec128(input logic [127:0] c, input logic [127:0] key);
    return {dec_blk(c[95:64], c[127:96], key), dec_blk(c[31:0], c[63:32], key)};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: pop and compare on every ready pulse; track data_o hold between pulses
  logic [127:0] last_data = '0;
  bit           hold_ok   = 1'b1;
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        last_data = '0;
        hold_ok   = 1'b1;
      end else if (ready) begin
        if (sb.size() == 0) begin
          check("spurious_ready", 128'(ready), 128'(0));
        end else begin
          e = sb.pop_front();
          check("ciphertext", data_o, e.ct);
          check("roundtrip", dec128(data_o, e.key), e.pt);
          check("latency", 128'(edge_cnt - e.e0), 128'(LAT));
          check("busy_at_ready", 128'(busy), 128'(0));
          check("hold_before", 128'(hold_ok), 128'(1));
        end
        last_data = data_o;
        hold_ok   = 1'b1;
      end else if (data_o !== last_data) begin
        hold_ok = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (busy) check("idle_timeout", 128'(busy), 128'(0));
  endtask

  task automatic issue(input logic [127:0] pv, input logic [127:0] pk, output int e0);
    exp_t e;
    wait_idle();
    v = pv;
    k = pk;
    start = 1'b1;
    e0 = edge_cnt + 1;
    e.ct = enc128(pv, pk); e.pt = pv; e.key = pk; e.e0 = e0;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    check("done_timeout", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    int e0, early;
    logic [127:0] pv, pk, a, b;
    exp_t e;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_ready", 128'(ready), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_data", data_o, 128'(0));
    reset = 1'b1;
    @(negedge clock);

    // Zero vector
    issue('0, '0, e0);
    wait_done();
    check("zero_vec", data_o, 128'hF7131ED9_DEE9D4D8_F7131ED9_DEE9D4D8);

    // Standard vector on both pairs
    pv = {32'h45464748, 32'h41424344, 32'h45464748, 32'h41424344};
    pk = {32'h0C0D0E0F, 32'h08090A0B, 32'h04050607, 32'h00010203};
    issue(pv, pk, e0);
    wait_done();
    check("std_vec", data_o, 128'h72612CB5_497DF3D0_72612CB5_497DF3D0);

    // Input isolation: disturb inputs and pulse start mid-run
    issue(rand128(), rand128(), e0);
    repeat (20) @(negedge clock);
    v = rand128();
    k = rand128();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    early = 0;
    while (edge_cnt < e0 + LAT) begin
      if (!busy) early++;
      @(negedge clock);
    end
    check("busy_early", 128'(early), 128'(0));
    wait_done();
    repeat (LAT + 20) @(negedge clock);
    check("no_requeue", 128'(busy), 128'(0));

    // Reset mid-run
    issue(rand128(), rand128(), e0);
    while (edge_cnt < e0 + 39) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_ready", 128'(ready), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_data", data_o, 128'(0));
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    issue(rand128(), rand128(), e0);
    wait_done();

    // Back-to-back with start held across completions
    wait_idle();
    a = rand128();
    b = rand128();
    pk = rand128();
    v = a;
    k = pk;
    start = 1'b1;
    e0 = edge_cnt + 1;
    e.ct = enc128(a, pk); e.pt = a; e.key = pk; e.e0 = e0;
    sb.push_back(e);
    @(negedge clock);
    v = b;
    e.ct = enc128(b, pk); e.pt = b; e.key = pk; e.e0 = e0 + LAT + 1;
    sb.push_back(e);
    while (edge_cnt < e0 + LAT + 1) @(negedge clock);
    start = 1'b0;
    wait_done();

    // Random round-trip vectors
    for (int n = 0; n < 100; n++) issue(rand128(), rand128(), e0);
    wait_done();
    repeat (5) @(negedge clock);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
